// File: rtl/bch_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : bch_encoder_if
// Brief    : Bit-serial valid/ready link carrying message bits in and
//            codeword bits out of the BCH(63,51) encoder.
// Revision : 1.0  initial release
// ============================================================================
interface bch_encoder_if;
    logic in_valid;
    logic in_data;
    logic in_ready;
    logic out_valid;
    logic out_data;
    logic out_ready;
    logic out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/bch_encoder.sv
`default_nettype none
// ============================================================================
// Module   : bch_encoder
// Brief    : Systematic bit-serial BCH(63,51) encoder, MSB-first, appends
//            12 parity bits after the 51 pass-through message bits.
// Revision : 1.0  initial release
// ============================================================================
module bch_encoder #(
    parameter logic [12:0] GEN_POLY = 13'b1_0101_0011_1001,
    parameter int          K        = 51,
    parameter int          N        = 63
) (
    input  wire logic   clk,
    input  wire logic   rst,
    bch_encoder_if.slave bus
);

    localparam logic [0:0] ST_MSG    = 1'b0;
    localparam logic [0:0] ST_PARITY = 1'b1;

    localparam logic [5:0] c_msg_last = 6'(K - 1);
    localparam logic [5:0] c_par_last = 6'(N - K - 1);

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [11:0] r_lfsr;
    logic [5:0]  r_bit_cnt;
    logic        r_out_valid;
    logic        r_out_data;
    logic        r_out_last;

    logic        w_free;
    logic        w_in_ready;
    logic        w_msg_load;
    logic        w_par_load;
    logic        w_msg_end;
    logic        w_par_end;
    logic        w_fb;
    logic [11:0] w_lfsr_shift;

    assign w_free       = ~r_out_valid | bus.out_ready;
    assign w_fb         = bus.in_data ^ r_lfsr[11];
    assign w_lfsr_shift = {r_lfsr[10:0], 1'b0};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_MSG;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_MSG:    if (w_msg_end) w_state_next = ST_PARITY;
            ST_PARITY: if (w_par_end) w_state_next = ST_MSG;
            default:   w_state_next = ST_MSG;
        endcase
    end

    // Output / load-strobe logic; in_ready is gated by rst so nothing is
    // accepted in the cycle that reset is being applied.
    always_comb begin
        w_in_ready = 1'b0;
        w_par_load = 1'b0;
        case (r_state)
            ST_MSG:    w_in_ready = w_free & ~rst;
            ST_PARITY: w_par_load = w_free;
            default:   w_in_ready = 1'b0;
        endcase
        w_msg_load = w_in_ready & bus.in_valid;
        w_msg_end  = w_msg_load & (r_bit_cnt == c_msg_last);
        w_par_end  = w_par_load & (r_bit_cnt == c_par_last);
    end

    // Datapath: output register, remainder LFSR and frame position
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 1'b0;
            r_out_last  <= 1'b0;
            r_lfsr      <= '0;
            r_bit_cnt   <= '0;
        end else begin
            if (w_free) begin
                r_out_valid <= w_msg_load | w_par_load;
                r_out_last  <= w_par_end;
                if (w_msg_load) begin
                    r_out_data <= bus.in_data;
                end else if (w_par_load) begin
                    r_out_data <= r_lfsr[11];
                end
            end

            if (w_msg_load) begin
                r_lfsr    <= w_lfsr_shift ^ (w_fb ? GEN_POLY[11:0] : 12'h000);
                r_bit_cnt <= w_msg_end ? 6'd0 : r_bit_cnt + 6'd1;
            end else if (w_par_load) begin
                r_lfsr    <= w_par_end ? 12'h000 : w_lfsr_shift;
                r_bit_cnt <= w_par_end ? 6'd0 : r_bit_cnt + 6'd1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;

endmodule
`default_nettype wire

// File: doc/bch_encoder.md
Name: bch_encoder

Overview:
- Systematic BCH(63,51) double-error-correcting encoder over GF(2^6), primitive polynomial x^6+x+1.
- Sits directly upstream of the BCH decoder on the bit-serial valid/ready link.
- Takes 51 message bits and passes them through unchanged, then appends 12 parity bits. Each 63-bit codeword has zero S1/S3 syndromes at the decoder.

Parameters:
- GEN_POLY, 13'b1_0101_0011_1001, generator g(x)=x^12+x^10+x^8+x^5+x^4+x^3+1 (octal 12471), MSB = x^12.
- K, 51, message bits per codeword.
- N, 63, codeword length; N-K must equal 12, the degree of GEN_POLY.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  message bit valid
- in_data  in  1  message bit, MSB-first (first bit = coefficient of x^62)
- in_ready  out  1  encoder accepts a message bit this cycle
- out_valid  out  1  codeword bit valid
- out_data  out  1  codeword bit, MSB-first
- out_ready  in  1  downstream (decoder) accepts a bit
- out_last  out  1  high with the final (63rd) codeword bit

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high on ports clk, rst.
- Reset values:
  - out_valid=0, out_data=0, out_last=0
  - lfsr=0, bit_cnt=0, state=ST_MSG
  - in_ready forced 0 while rst=1
- Output register: one-bit output register (out_data, out_valid, out_last).
  - The register is "free" when ~out_valid | out_ready.
  - When it is free and has no new bit to load, out_valid<=0 next cycle.
- State ST_MSG:
  - in_ready = free (combinational).
  - On in_valid & in_ready:
    - out_data<=in_data, out_valid<=1
    - fb=in_data^lfsr[11]
    - lfsr<={lfsr[10:0],0} ^ (fb ? GEN_POLY[11:0] : 0)
    - bit_cnt++
  - When the K-th bit is accepted (bit_cnt==K-1): bit_cnt<=0, state<=ST_PARITY.
- State ST_PARITY:
  - in_ready=0.
  - On free: out_data<=lfsr[11], out_valid<=1, lfsr<={lfsr[10:0],0}, bit_cnt++.
  - On loading the 12th parity bit (bit_cnt==N-K-1): out_last<=1, bit_cnt<=0, lfsr<=0, state<=ST_MSG.
  - out_last clears when that bit is consumed.
- Latency: 1 cycle from input accept to out_valid.
- Throughput: 1 bit/cycle when out_ready is held high. A full codeword takes 63 consecutive cycles with no bubble between message and parity.
- Backpressure:
  - While out_valid & ~out_ready: out_data, out_valid and out_last hold stable.
  - No input is accepted and no LFSR or counter update occurs.
- in_valid low mid-message: output bubbles, the LFSR holds, and the frame position is kept.
- Frame-boundary wrap: after the last parity bit loads, the next message bit of the following frame may be accepted in the same cycle the last parity bit is consumed. There is no idle gap.
- Reset mid-frame: the partial codeword is discarded. The first accepted bit after reset is x^62 of a new frame.
- Arithmetic: all GF(2) XOR. bit_cnt is 6 bits and never exceeds 50.

Test Plan:
- All-zero message (51 zeros), out_ready=1 -> 63 zero output bits; out_last high on cycle 63 only; no bubbles.
- Message with only the last message bit =1 (bit 51, x^12) -> parity MSB-first = 0,1,0,1,0,0,1,1,1,0,0,1 (0x539).
- 200 random messages looped through the BCH decoder -> decoded 51 bits equal input and S1=S3=0 every frame. With 1 or 2 bits flipped per codeword on the link, output is still corrected.
- Random out_ready (50%) and in_valid (70%) -> output stable during stalls; no bit lost or duplicated; parity matches a reference model.
- rst asserted after 30 message bits, then a fresh all-ones message -> outputs idle during reset. The codeword equals the golden all-ones encoding with no residue from the aborted frame.
- Two back-to-back frames with out_ready=1 -> 126 consecutive valid cycles; in_ready low for exactly 12 cycles per frame.
